uart_config_responder: RTL and testbench

//  Slave-side responder of the configuration handshake. After a session start it pops packets from the
//  RX path, decodes the {dont_care, option, id} fields into a shadow config and answers each legal packet

---
 rtl/uart_config_responder_pkg.sv | 51 +++++
 rtl/uart_config_responder_timeout_counter.sv | 30 +++
 rtl/uart_config_responder.sv | 144 ++++++++++++++
 tb/tb_uart_config_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_config_responder_pkg.sv
// Shared types and constants for the UART configuration handshake.
package uart_config_responder_pkg;

  localparam int unsigned COUNT_50MS = 5_000_000;
  localparam logic [7:0]  ACKN_PKT   = 8'hFF;

  // Packet identifiers (low two bits of a config packet)
  localparam logic [1:0] END_CONFIGURATION_ID = 2'd0;
  localparam logic [1:0] DATA_WIDTH_ID        = 2'd1;
  localparam logic [1:0] PARITY_MODE_ID       = 2'd2;
  localparam logic [1:0] STOP_BITS_ID         = 2'd3;

  // Option encodings needed by this block
  localparam logic [1:0] DW_8BIT          = 2'd3;
  localparam logic [1:0] PARITY_DISABLED1 = 2'd0;
  localparam logic [1:0] SB_1BIT          = 2'd0;
  localparam logic [1:0] SB_2BIT          = 2'd1;

  localparam logic [1:0] STD_DATA_WIDTH  = DW_8BIT;
  localparam logic [1:0] STD_PARITY_MODE = PARITY_DISABLED1;
  localparam logic [1:0] STD_STOP_BITS   = SB_1BIT;

  typedef struct packed {
    logic [1:0] data_width;
    logic [1:0] parity_mode;
    logic [1:0] stop_bits;
  } uart_config_s;

  typedef struct packed {
    logic [3:0] dont_care;
    logic [1:0] option;
    logic [1:0] id;
  } data_packet_s;

  typedef union packed {
    logic [7:0]   raw;
    data_packet_s fields;
  } data_packet_u;

  localparam uart_config_s STD_CONFIGURATION =
    uart_config_s'({STD_DATA_WIDTH, STD_PARITY_MODE, STD_STOP_BITS});

  typedef enum logic [1:0] {IDLE, WAIT_PKT, DECODE, SEND_ACK} cfg_resp_fsm_e;

  // Only the two real stop-bit settings are accepted; the other encodings are reserved.
  function automatic logic is_illegal_packet(data_packet_u pkt);
    return (pkt.fields.id == STOP_BITS_ID) &&
           !((pkt.fields.option == SB_1BIT) || (pkt.fields.option == SB_2BIT));
  endfunction

endpackage

// File: rtl/uart_config_responder_timeout_counter.sv
// Saturating idle counter; expire_c fires on the cycle the count reaches LIMIT-1.
module uart_timeout_counter #(
  parameter int unsigned LIMIT = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Expiry is combinational so the owner can react in the same cycle
  assign expire_c = enable_i && !clear_i && (count == CNT_W'(LIMIT - 1));

  // Count enabled cycles, saturating at LIMIT so the value never wraps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (enable_i && (count != CNT_W'(LIMIT))) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_config_responder.sv
// Slave-side config handshake: pop packets, build shadow config, ACK each, commit on END.
module uart_config_responder
  import uart_config_responder_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = COUNT_50MS,
  parameter logic [7:0]  ACK_BYTE       = ACKN_PKT
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cfg_start_i,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic         rx_ready_o,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output uart_config_s config_o,
  output logic         cfg_active_o,
  output logic         cfg_done_o,
  output logic         cfg_error_o
);

  cfg_resp_fsm_e state, state_next;
  data_packet_u  pkt_q, pkt_d;
  uart_config_s  shadow_q, shadow_d, config_d;
  logic          end_q, end_d;
  logic [7:0]    tx_data_d;
  logic          rx_ready_d, tx_valid_d, cfg_active_d, cfg_done_d, cfg_error_d;
  logic          pop_c, illegal_c, timeout_c, timer_enable_c, timer_clear_c;
  logic          unused_dont_care;

  assign pop_c          = (state == WAIT_PKT) && rx_valid_i && rx_ready_o;
  assign illegal_c      = is_illegal_packet(pkt_q);
  assign timer_enable_c = (state == WAIT_PKT) && !pop_c;
  assign timer_clear_c  = !timer_enable_c;
  assign unused_dont_care = ^pkt_q.fields.dont_care;

  // Idle-wait timer only runs while waiting for a packet
  uart_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (timer_clear_c),
    .enable_i (timer_enable_c),
    .expire_c (timeout_c)
  );

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      pkt_q        <= '0;
      shadow_q     <= STD_CONFIGURATION;
      end_q        <= 1'b0;
      config_o     <= STD_CONFIGURATION;
      rx_ready_o   <= 1'b0;
      tx_data_o    <= 8'h00;
      tx_valid_o   <= 1'b0;
      cfg_active_o <= 1'b0;
      cfg_done_o   <= 1'b0;
      cfg_error_o  <= 1'b0;
    end else begin
      state        <= state_next;
      pkt_q        <= pkt_d;
      shadow_q     <= shadow_d;
      end_q        <= end_d;
      config_o     <= config_d;
      rx_ready_o   <= rx_ready_d;
      tx_data_o    <= tx_data_d;
      tx_valid_o   <= tx_valid_d;
      cfg_active_o <= cfg_active_d;
      cfg_done_o   <= cfg_done_d;
      cfg_error_o  <= cfg_error_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (cfg_start_i) state_next = WAIT_PKT;
      WAIT_PKT: begin
        if (pop_c)          state_next = DECODE;
        else if (timeout_c) state_next = IDLE;
      end
      DECODE:   state_next = illegal_c ? IDLE : SEND_ACK;
      SEND_ACK: if (tx_ready_i) state_next = end_q ? IDLE : WAIT_PKT;
      default:  state_next = IDLE;
    endcase
  end

  // Next values of datapath and output registers
  always_comb begin
    pkt_d        = pkt_q;
    shadow_d     = shadow_q;
    end_d        = end_q;
    config_d     = config_o;
    tx_data_d    = tx_data_o;
    tx_valid_d   = tx_valid_o;
    cfg_done_d   = 1'b0;
    cfg_error_d  = 1'b0;
    rx_ready_d   = (state_next == WAIT_PKT);
    cfg_active_d = (state_next != IDLE);
    case (state)
      IDLE: begin
        if (cfg_start_i) begin
          shadow_d = config_o;
          end_d    = 1'b0;
        end
      end
      WAIT_PKT: begin
        if (pop_c)          pkt_d.raw   = rx_data_i;
        else if (timeout_c) cfg_error_d = 1'b1;
      end
      DECODE: begin
        case (pkt_q.fields.id)
          END_CONFIGURATION_ID: end_d                = 1'b1;
          DATA_WIDTH_ID:        shadow_d.data_width  = pkt_q.fields.option;
          PARITY_MODE_ID:       shadow_d.parity_mode = pkt_q.fields.option;
          STOP_BITS_ID:         if (!illegal_c) shadow_d.stop_bits = pkt_q.fields.option;
          default: ;
        endcase
        if (illegal_c) begin
          cfg_error_d = 1'b1;
        end else begin
          tx_data_d  = ACK_BYTE;
          tx_valid_d = 1'b1;
        end
      end
      SEND_ACK: begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          if (end_q) begin
            config_d   = shadow_q;
            cfg_done_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_uart_config_responder.sv
// Directed bench for uart_config_responder with a cycle-level reference model.
module tb_uart_config_responder;

  localparam int unsigned TO = 20;

  logic       clk = 1'b0;
  logic       rst, cfg_start, rx_valid, tx_ready;
  logic [7:0] rx_data, tx_data;
  logic       rx_ready, tx_valid, active, done, err;
  logic [5:0] cfg;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  uart_config_responder #(
    .TIMEOUT_CYCLES (TO),
    .ACK_BYTE       (8'hFF)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_start_i  (cfg_start),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .tx_data_o    (tx_data),
    .tx_valid_o   (tx_valid),
    .tx_ready_i   (tx_ready),
    .config_o     (cfg),
    .cfg_active_o (active),
    .cfg_done_o   (done),
    .cfg_error_o  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow/committed config held as three integers, session as flags
  int         m_dw = 3, m_pm = 0, m_sb = 0, m_cdw = 3, m_cpm = 0, m_csb = 0;
  int         m_idle = 0, m_id = 0, m_opt = 0;
  bit         m_active = 0, m_rx_ready = 0, m_tx_valid = 0, m_done = 0, m_err = 0;
  bit         m_end = 0, m_have = 0;
  logic [7:0] m_byte = 8'h00, m_tx_data = 8'h00;

  initial forever begin
    @(posedge clk or posedge rst);
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_cdw = 3; m_cpm = 0; m_csb = 0; m_dw = 3; m_pm = 0; m_sb = 0;
      m_active = 0; m_rx_ready = 0; m_tx_valid = 0; m_tx_data = 8'h00;
      m_end = 0; m_have = 0; m_idle = 0;
    end else if (!m_active) begin
      if (cfg_start) begin
        m_active = 1; m_rx_ready = 1; m_idle = 0; m_end = 0;
        m_dw = m_cdw; m_pm = m_cpm; m_sb = m_csb;
      end
    end else if (m_rx_ready) begin
      if (rx_valid) begin
        m_byte = rx_data; m_have = 1; m_rx_ready = 0; m_idle = 0;
      end else if (m_idle == int'(TO) - 1) begin
        m_err = 1; m_active = 0; m_rx_ready = 0;
      end else begin
        m_idle++;
      end
    end else if (m_have) begin
      m_have = 0;
      m_id   = int'(m_byte) % 4;
      m_opt  = (int'(m_byte) / 4) % 4;
      if (m_id == 3 && m_opt >= 2) begin
        m_err = 1; m_active = 0;
      end else begin
        case (m_id)
          0:       m_end = 1;
          1:       m_dw  = m_opt;
          2:       m_pm  = m_opt;
          default: m_sb  = m_opt;
        endcase
        m_tx_valid = 1; m_tx_data = 8'hFF;
      end
    end else if (m_tx_valid && tx_ready) begin
      m_tx_valid = 0;
      if (m_end) begin
        m_cdw = m_dw; m_cpm = m_pm; m_csb = m_sb; m_done = 1; m_active = 0;
      end else begin
        m_rx_ready = 1; m_idle = 0;
      end
    end
  end

  // Compare every output against the model on the falling edge
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("config_o",     32'(cfg),      32'(m_cdw * 16 + m_cpm * 4 + m_csb));
      check("cfg_active_o", 32'(active),   32'(m_active));
      check("rx_ready_o",   32'(rx_ready), 32'(m_rx_ready));
      check("tx_valid_o",   32'(tx_valid), 32'(m_tx_valid));
      check("tx_data_o",    32'(tx_data),  32'(m_tx_data));
      check("cfg_done_o",   32'(done),     32'(m_done));
      check("cfg_error_o",  32'(err),      32'(m_err));
    end
  end

  // Event monitor for hand-computed expectations
  int cyc = 0, ack_cnt = 0, done_cnt = 0, err_cnt = 0, hs_cyc = 0, done_cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
    if (tx_valid && tx_ready) begin ack_cnt++; hs_cyc = cyc; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) err_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic start_session();
    cfg_start = 1'b1;
    @(posedge clk);
    #2 cfg_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (rx_ready) begin ok = 1'b1; break; end
    end
    #2 rx_valid = 1'b0;
    check("send_popped", 32'(ok), 32'd1);
  endtask

  int a0, d0, e0, err_at;

  initial begin
    rst = 1'b1; cfg_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 chk_en = 1'b1;
    rst = 1'b0;
    tick(1);

    // 1: reset state
    check("rst_config", 32'(cfg), 32'h30);
    check("rst_active", 32'(active), 32'd0);
    check("rst_strobes", 32'({rx_ready, tx_valid, done, err}), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);

    // 2: full session, four ACKs then commit
    a0 = ack_cnt; d0 = done_cnt;
    start_session();
    send(8'h01); send(8'h06); send(8'h07); send(8'h00);
    tick(4);
    check("s2_acks", 32'(ack_cnt - a0), 32'd4);
    check("s2_done", 32'(done_cnt - d0), 32'd1);
    check("s2_commit_latency", 32'(done_cyc - hs_cyc), 32'd1);
    check("s2_config", 32'(cfg), 32'h05);

    // 3: reserved stop-bit option aborts the session
    a0 = ack_cnt; e0 = err_cnt;
    start_session();
    send(8'h02); send(8'h0B);
    tick(3);
    check("s3_acks", 32'(ack_cnt - a0), 32'd1);
    check("s3_err", 32'(err_cnt - e0), 32'd1);
    check("s3_config", 32'(cfg), 32'h05);
    check("s3_active", 32'(active), 32'd0);

    // 4: idle timeout after TO cycles
    err_at = 0;
    start_session();
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (err) begin err_at = c; break; end
    end
    #1;
    check("s4_timeout_cycle", 32'(err_at), 32'd20);
    tick(1);
    check("s4_config", 32'(cfg), 32'h05);
    check("s4_active", 32'(active), 32'd0);

    // 5: TX backpressure never times out; stray start is ignored
    e0 = err_cnt;
    start_session();
    tx_ready = 1'b0;
    send(8'h0D);
    tick(5);
    start_session();
    tick(50);
    check("s5_tx_valid_held", 32'(tx_valid), 32'd1);
    check("s5_tx_data_held", 32'(tx_data), 32'hFF);
    check("s5_still_active", 32'(active), 32'd1);
    check("s5_no_timeout", 32'(err_cnt - e0), 32'd0);
    tx_ready = 1'b1;
    send(8'h00);
    tick(4);
    check("s5_config", 32'(cfg), 32'h35);

    // 6: dont_care bits ignored, last write wins
    start_session();
    send(8'hF1); send(8'h05); send(8'h00);
    tick(4);
    check("s6_config", 32'(cfg), 32'h15);

    // 6b: reset while holding an ACK
    start_session();
    tx_ready = 1'b0;
    send(8'h0A);
    tick(3);
    check("s6_in_send_ack", 32'(tx_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("s6_rst_tx_valid", 32'(tx_valid), 32'd0);
    check("s6_rst_active", 32'(active), 32'd0);
    check("s6_rst_config", 32'(cfg), 32'h30);
    tick(2);
    rst = 1'b0;
    tx_ready = 1'b1;
    tick(3);
    check("s6_post_rst_config", 32'(cfg), 32'h30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
